// File: rtl/sel_scanner_pkg.sv
// -----------------------------------------------------------------------------
// sel_scanner_pkg
// Shared types and constants for the decoder select scanner.
//   state_t   : scanner FSM states (IDLE, RUN)
//   CODE_W    : width of the select code {X1, X0}
//   PASS_LEN  : number of codes presented in one one-shot pass
//   PASS_W    : width of the pass counter
//   next_code : one 2-bit step up or down, with natural wrap
// -----------------------------------------------------------------------------
package sel_scanner_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int CODE_W   = 2;
    localparam int PASS_LEN = 4;
    localparam int PASS_W   = $clog2(PASS_LEN);

    // Advance a select code by one position; down=1 subtracts, else adds.
    function automatic logic [CODE_W-1:0] next_code(input logic [CODE_W-1:0] code,
                                                     input logic              down);
        logic [CODE_W-1:0] res;
        if (down) begin
            res = code - CODE_W'(1);
        end else begin
            res = code + CODE_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/sel_scanner_dwell_timer.sv
// -----------------------------------------------------------------------------
// sel_dwell_timer
// Dwell counter for the select scanner. Counts enabled cycles and raises tc
// while the count equals limit; on an enabled terminal cycle it wraps to zero
// so the next dwell starts immediately.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   clr   : synchronous clear (wins over en)
//   en    : count enable
//   limit : terminal count value (dwell)
//   tc    : terminal count reached (count == limit)
// -----------------------------------------------------------------------------
module sel_dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [DWELL_W-1:0] limit,
    output logic               tc
);

    logic [DWELL_W-1:0] count_r;

    assign tc = (count_r == limit);

    // Dwell count register: clear, wrap on terminal count, or increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en) begin
            if (tc) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + DWELL_W'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/sel_scanner.sv
// -----------------------------------------------------------------------------
// sel_scanner
// Sequencer producing the registered 2-bit select {X1, X0} for a 2-to-4
// one-hot decoder. Each code is held dwell+1 cycles; scanning is free-running
// or one-shot (four codes), upward or downward.
// Optional feature macro: SEL_SCANNER_PINGPONG_EN adds a pingpong input that
// makes the scan bounce at codes 0 and 3 instead of wrapping.
// Ports:
//   clk, rst_n     : clock / synchronous active-low reset
//   start, stop    : scan control pulses (stop wins)
//   oneshot, dir   : pass mode and direction, sampled at start
//   dwell          : hold length minus one, sampled at start
//   load/load_code : force the code (wins over an advance)
//   pingpong       : bounce mode, sampled at start (macro builds only)
//   X1, X0         : registered select code
//   busy           : scanner in RUN
//   step           : first cycle a newly advanced code is visible
//   done           : one-shot pass finished (falls with busy)
// -----------------------------------------------------------------------------
module sel_scanner
    import sel_scanner_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               oneshot,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               load,
    input  logic [1:0]         load_code,
`ifdef SEL_SCANNER_PINGPONG_EN
    input  logic               pingpong,
`endif
    output logic               X1,
    output logic               X0,
    output logic               busy,
    output logic               step,
    output logic               done
);

    state_t              state_r,   state_n_s;
    logic [CODE_W-1:0]   code_r,    code_n_s;
    logic [PASS_W-1:0]   pass_r,    pass_n_s;
    logic [DWELL_W-1:0]  dwell_r,   dwell_n_s;
    logic                dir_r,     dir_n_s;
    logic                oneshot_r, oneshot_n_s;
    logic                step_r,    step_n_s;
    logic                done_r,    done_n_s;
    logic                tmr_clr_s, tmr_en_s, tmr_tc_s;
    logic                dir_eff_s, dir_adv_s;
    logic [CODE_W-1:0]   adv_code_s;
`ifdef SEL_SCANNER_PINGPONG_EN
    logic                pingpong_r, pingpong_n_s;
`endif

    sel_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr_s),
        .en    (tmr_en_s),
        .limit (dwell_r),
        .tc    (tmr_tc_s)
    );

    // Candidate advance: code and direction that apply if this cycle advances.
    always_comb begin
        dir_eff_s = dir_r;
        dir_adv_s = dir_r;
`ifdef SEL_SCANNER_PINGPONG_EN
        // Already sitting at the end we are heading to: turn around first.
        if (pingpong_r && ((!dir_r && code_r == 2'd3) || (dir_r && code_r == 2'd0))) begin
            dir_eff_s = !dir_r;
        end else begin
            dir_eff_s = dir_r;
        end
`endif
        adv_code_s = next_code(code_r, dir_eff_s);
        dir_adv_s  = dir_eff_s;
`ifdef SEL_SCANNER_PINGPONG_EN
        // Reaching an end flips direction so the following step bounces back.
        if (pingpong_r && adv_code_s == 2'd3) begin
            dir_adv_s = 1'b1;
        end else if (pingpong_r && adv_code_s == 2'd0) begin
            dir_adv_s = 1'b0;
        end else begin
            dir_adv_s = dir_eff_s;
        end
`endif
    end

    // FSM next-state and datapath next-values.
    always_comb begin
        state_n_s   = state_r;
        code_n_s    = code_r;
        pass_n_s    = pass_r;
        dwell_n_s   = dwell_r;
        dir_n_s     = dir_r;
        oneshot_n_s = oneshot_r;
        step_n_s    = 1'b0;
        done_n_s    = 1'b0;
        tmr_clr_s   = 1'b0;
        tmr_en_s    = 1'b0;
`ifdef SEL_SCANNER_PINGPONG_EN
        pingpong_n_s = pingpong_r;
`endif
        case (state_r)
            IDLE: begin
                if (start && !stop) begin
                    state_n_s   = RUN;
                    dwell_n_s   = dwell;
                    dir_n_s     = dir;
                    oneshot_n_s = oneshot;
`ifdef SEL_SCANNER_PINGPONG_EN
                    pingpong_n_s = pingpong;
`endif
                    tmr_clr_s   = 1'b1;
                    pass_n_s    = '0;
                end else begin
                    state_n_s = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n_s = IDLE;
                end else if (start) begin
                    // Restart the pass in place from the current code.
                    dwell_n_s   = dwell;
                    dir_n_s     = dir;
                    oneshot_n_s = oneshot;
`ifdef SEL_SCANNER_PINGPONG_EN
                    pingpong_n_s = pingpong;
`endif
                    tmr_clr_s   = 1'b1;
                    pass_n_s    = '0;
                end else if (load) begin
                    tmr_clr_s = 1'b1;
                    pass_n_s  = '0;
                end else begin
                    tmr_en_s = 1'b1;
                    if (tmr_tc_s) begin
                        // Fourth code has finished its dwell: end the pass.
                        if (oneshot_r && pass_r == PASS_W'(PASS_LEN - 1)) begin
                            state_n_s = IDLE;
                            done_n_s  = 1'b1;
                        end else begin
                            code_n_s = adv_code_s;
                            dir_n_s  = dir_adv_s;
                            step_n_s = 1'b1;
                            pass_n_s = pass_r + PASS_W'(1);
                        end
                    end else begin
                        state_n_s = RUN;
                    end
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
        // load owns the code in either state and suppresses any advance.
        if (load) begin
            code_n_s = load_code;
        end else begin
            code_n_s = code_n_s;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            code_r    <= '0;
            pass_r    <= '0;
            dwell_r   <= '0;
            dir_r     <= 1'b0;
            oneshot_r <= 1'b0;
            step_r    <= 1'b0;
            done_r    <= 1'b0;
`ifdef SEL_SCANNER_PINGPONG_EN
            pingpong_r <= 1'b0;
`endif
        end else begin
            state_r   <= state_n_s;
            code_r    <= code_n_s;
            pass_r    <= pass_n_s;
            dwell_r   <= dwell_n_s;
            dir_r     <= dir_n_s;
            oneshot_r <= oneshot_n_s;
            step_r    <= step_n_s;
            done_r    <= done_n_s;
`ifdef SEL_SCANNER_PINGPONG_EN
            pingpong_r <= pingpong_n_s;
`endif
        end
    end

    assign X1   = code_r[1];
    assign X0   = code_r[0];
    assign busy = (state_r == RUN);
    assign step = step_r;
    assign done = done_r;

endmodule

// File: tb/tb_sel_scanner.sv
// Directed bench for sel_scanner: linear stimulus with hand-computed results.
module tb_sel_scanner;

    logic       clk = 1'b0;
    logic       rst_n, start, stop, oneshot, dir, load;
    logic [7:0] dwell;
    logic [1:0] load_code;
`ifdef SEL_SCANNER_PINGPONG_EN
    logic       pingpong;
`endif
    logic       X1, X0, busy, step, done;

    int checks = 0;
    int errors = 0;

    sel_scanner #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .oneshot   (oneshot),
        .dir       (dir),
        .dwell     (dwell),
        .load      (load),
        .load_code (load_code),
`ifdef SEL_SCANNER_PINGPONG_EN
        .pingpong  (pingpong),
`endif
        .X1        (X1),
        .X0        (X0),
        .busy      (busy),
        .step      (step),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int code, input int b, input int s, input int d);
        chk({tag, "_code"}, {30'd0, X1, X0}, code[31:0]);
        chk({tag, "_busy"}, {31'd0, busy}, b[31:0]);
        chk({tag, "_step"}, {31'd0, step}, s[31:0]);
        chk({tag, "_done"}, {31'd0, done}, d[31:0]);
    endtask

    initial begin
        int ec;
        rst_n = 1'b0; start = 1'b1; stop = 1'b0; oneshot = 1'b0; dir = 1'b0;
        dwell = 8'd0; load = 1'b0; load_code = 2'd0;
`ifdef SEL_SCANNER_PINGPONG_EN
        pingpong = 1'b0;
`endif
        // Reset wins over a held start.
        tick(); tick();
        chk_all("reset", 0, 0, 0, 0);
        rst_n = 1'b1; start = 1'b0;
        tick();
        chk_all("post_reset", 0, 0, 0, 0);

        // One-shot up, dwell=2: 00,01,10,11 each 3 cycles, done at 12.
        start = 1'b1; dir = 1'b0; dwell = 8'd2; oneshot = 1'b1;
        tick();
        start = 1'b0;
        chk_all("os_t0", 0, 1, 0, 0);
        for (int t = 1; t <= 12; t++) begin
            tick();
            ec = (t / 3 > 3) ? 3 : t / 3;
            chk_all($sformatf("os_t%0d", t), ec, (t < 12) ? 1 : 0,
                    (t % 3 == 0 && t < 12) ? 1 : 0, (t == 12) ? 1 : 0);
        end
        tick();
        chk_all("os_after", 3, 0, 0, 0);

        // Load in IDLE, then free-run down with dwell=0.
        load = 1'b1; load_code = 2'd0;
        tick();
        load = 1'b0;
        chk_all("idle_load", 0, 0, 0, 0);
        start = 1'b1; dir = 1'b1; dwell = 8'd0; oneshot = 1'b0;
        tick();
        start = 1'b0;
        chk_all("dn_t0", 0, 1, 0, 0);
        for (int t = 1; t <= 6; t++) begin
            tick();
            chk_all($sformatf("dn_t%0d", t), (4 - (t % 4)) % 4, 1, 1, 0);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_all("dn_stop", 2, 0, 0, 0);

        // Stop in second cycle of a dwell=5 scan.
        start = 1'b1; dir = 1'b0; dwell = 8'd5;
        tick();
        start = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_all("stop5", 2, 0, 0, 0);
        tick(); tick(); tick(); tick();
        chk_all("stop5_hold", 2, 0, 0, 0);

        // start and stop together from IDLE.
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk_all("start_stop", 2, 0, 0, 0);

        // Load collides with a due advance; pass restarts from load_code.
        load = 1'b1; load_code = 2'd0;
        tick();
        load = 1'b0;
        start = 1'b1; dir = 1'b0; dwell = 8'd1; oneshot = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_all("ld_pre", 0, 1, 0, 0);
        load = 1'b1; load_code = 2'd2;
        tick();
        load = 1'b0;
        chk_all("ld_m0", 2, 1, 0, 0);
        for (int t = 1; t <= 8; t++) begin
            tick();
            ec = (t / 2 > 3) ? 3 : t / 2;
            chk_all($sformatf("ld_m%0d", t), (2 + ec) % 4, (t < 8) ? 1 : 0,
                    (t % 2 == 0 && t < 8) ? 1 : 0, (t == 8) ? 1 : 0);
        end

`ifdef SEL_SCANNER_PINGPONG_EN
        // Ping-pong free run from 00: 01,10,11,10,01,00,01.
        load = 1'b1; load_code = 2'd0;
        tick();
        load = 1'b0;
        start = 1'b1; dir = 1'b0; dwell = 8'd0; oneshot = 1'b0; pingpong = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            ec = (t <= 3) ? t : ((t <= 6) ? 6 - t : t - 6);
            chk_all($sformatf("pp_t%0d", t), ec, 1, 1, 0);
        end
        pingpong = 1'b0;
`endif

        // Reset mid-scan beats start and load.
        load = 1'b1; load_code = 2'd1;
        tick();
        load = 1'b0;
        start = 1'b1; dir = 1'b0; dwell = 8'd0; oneshot = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick();
        chk_all("pre_rst", 3, 1, 1, 0);
        rst_n = 1'b0; start = 1'b1; load = 1'b1; load_code = 2'd3;
        tick();
        chk_all("mid_rst", 0, 0, 0, 0);
        rst_n = 1'b1; start = 1'b0; load = 1'b0;
        tick();
        chk_all("mid_rst_after", 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
